game_round_ctrl: RTL and testbench
==================================

GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 SHALL have parameter ROUND_SECONDS, default 30, the length of the play phase in seconds; legal range 1..63.
REQ-002 SHALL have parameter READY_SECONDS, default 3, the length of the pre-round countdown in seconds; legal range 1..63.
REQ-003 SHALL have port clk_in, input, 1 bit: 100 MHz system clock; the design has one clock.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port tick_1hz, input, 1 bit: one-cycle pulse, once per second, from the 1 Hz game timer pulse generator.
REQ-006 SHALL have port start_btn, input, 1 bit: debounced one-cycle start pulse.
REQ-007 SHALL have port hit, input, 1 bit: one-cycle pulse for each successful mole hit.
REQ-008 SHALL have port pause, input, 1 bit: level input; present only under GAME_PAUSE_EN.
REQ-009 SHALL have port state, output, 2 bits: IDLE=0, READY=1, PLAY=2, OVER=3.
REQ-010 SHALL have port time_left, output, 6 bits: seconds remaining in the current phase.
REQ-011 SHALL have port score, output, 8 bits: hit count for the current round.
REQ-012 SHALL have port mole_en, output, 1 bit: high while moles may be displayed or hit.
REQ-013 SHALL have port round_done, output, 1 bit: one-cycle pulse on entry to OVER.

Function
REQ-014 SHALL implement an FSM with states IDLE, READY, PLAY and OVER, with all outputs registered.
REQ-015 SHALL, in IDLE on start_btn, go to READY on the next cycle, load time_left=READY_SECONDS and clear score to 0.
REQ-016 SHALL, in READY, decrement time_left on each tick_1hz while time_left>1.
REQ-017 SHALL, in READY, go to PLAY on the tick_1hz seen with time_left==1, loading time_left=ROUND_SECONDS.
REQ-018 SHALL, in PLAY, decrement time_left on each tick_1hz while time_left>1.
REQ-019 SHALL, in PLAY, go to OVER on the tick_1hz seen with time_left==1, setting time_left=0 and pulsing round_done for exactly one cycle.
REQ-020 SHALL, in OVER, hold score and time_left=0; on start_btn, act as in REQ-015.
REQ-021 SHALL ignore start_btn in READY and PLAY; a round is never restarted mid-play.
REQ-022 SHALL increment score by 1 for each hit seen while mole_en=1, saturating at 255 with no wrap.
REQ-023 SHALL ignore hit outside PLAY.
REQ-024 SHALL give the same cycle's hit priority over the transition when hit and the final tick_1hz coincide, so that hit is counted.
REQ-025 SHALL drive mole_en=1 only in PLAY, and not while paused.
REQ-026 SHALL treat a tick_1hz coinciding with start_btn in IDLE or OVER as no tick; the countdown starts from the full READY_SECONDS.
REQ-027 SHALL have a latency of one clk_in cycle from a qualifying input pulse to the resulting output change.

Reset
REQ-028 SHALL asynchronously force state=IDLE, time_left=0, score=0, mole_en=0 and round_done=0 on rst_n low.
REQ-029 SHALL abandon a round in progress on reset mid-round; no round_done pulse is generated.
REQ-030 SHALL leave IDLE on the first clk_in edge after rst_n deasserts only if start_btn is high on that edge.

Configuration
REQ-031 SHALL, with macro GAME_PAUSE_EN defined, provide the pause port; while pause=1 in READY or PLAY, tick_1hz is ignored, time_left freezes, mole_en=0 and hit is ignored.
REQ-032 SHALL, with GAME_PAUSE_EN undefined, omit the pause port and behave as if pause=0.

Structure
REQ-033 SHALL place the state encoding constants (IDLE/READY/PLAY/OVER), the 6-bit time width and the 8-bit score width in shared package game_pkg.
REQ-034 SHALL implement the loadable, tick-enabled 6-bit down-counter as sub-module phase_down_counter, with load, load_value, en and zero-flag outputs.

Verification
REQ-035 SHALL verify, with ROUND_SECONDS=5 and READY_SECONDS=3: start_btn, then 3 ticks -> state=PLAY, time_left=5; then 5 ticks -> state=OVER, time_left=0, round_done high for exactly 1 cycle.
REQ-036 SHALL verify 3 hits in PLAY plus 2 hits in READY -> score=3.
REQ-037 SHALL verify 300 hits in PLAY with a long round -> score=255.
REQ-038 SHALL verify hit coinciding with the final tick -> score incremented and state=OVER.
REQ-039 SHALL verify rst_n low during PLAY with time_left=2 -> immediately state=IDLE, score=0, mole_en=0, and no round_done.
REQ-040 SHALL verify, with GAME_PAUSE_EN defined: pause=1 in PLAY with time_left=4, then 3 ticks and 2 hits -> time_left=4, score unchanged, mole_en=0; after release, the next tick -> time_left=3.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and widths for the whack-a-mole round controller.
package game_pkg;

  localparam int TIME_W  = 6;
  localparam int SCORE_W = 8;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } game_state_e;

endpackage

// File: rtl/phase_down_counter.sv
// Loadable seconds counter; decrements on en and stops at zero.
module phase_down_counter
  import game_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              load,
  input  logic [TIME_W-1:0] load_value,
  input  logic              en,
  output logic [TIME_W-1:0] count,
  output logic              zero,
  output logic              one
);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);
  assign one  = (count == TIME_W'(1));

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer IDLE -> READY -> PLAY -> OVER with score keeping.
// Optional pause input is enabled by defining GAME_PAUSE_EN.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int ROUND_SECONDS = 30,
  parameter int READY_SECONDS = 3
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               tick_1hz,
  input  logic               start_btn,
  input  logic               hit,
`ifdef GAME_PAUSE_EN
  input  logic               pause,
`endif
  output logic [1:0]         state,
  output logic [TIME_W-1:0]  time_left,
  output logic [SCORE_W-1:0] score,
  output logic               mole_en,
  output logic               round_done
);

  localparam logic [TIME_W-1:0] READY_T = TIME_W'(READY_SECONDS);
  localparam logic [TIME_W-1:0] ROUND_T = TIME_W'(ROUND_SECONDS);

  logic pause_i;
`ifdef GAME_PAUSE_EN
  assign pause_i = pause;
`else
  assign pause_i = 1'b0;
`endif

  game_state_e       state_q, state_d;
  logic              cnt_load, cnt_en, cnt_zero, cnt_one;
  logic [TIME_W-1:0] cnt_load_value;
  logic              score_clr, score_inc;
  logic              phase_tick;

  // A paused phase sees no time passing.
  assign phase_tick = tick_1hz && !pause_i;

  phase_down_counter u_counter (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .en         (cnt_en),
    .count      (time_left),
    .zero       (cnt_zero),
    .one        (cnt_one)
  );

  always_comb begin
    state_d        = state_q;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    cnt_en         = 1'b0;
    score_clr      = 1'b0;
    // Hit is evaluated from the current state, so it wins over the final tick.
    score_inc      = (state_q == ST_PLAY) && !pause_i && hit && (score != SCORE_MAX);
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_btn) begin
          state_d        = ST_READY;
          cnt_load       = 1'b1;
          cnt_load_value = READY_T;
          score_clr      = 1'b1;
        end
      end
      ST_READY: begin
        if (phase_tick) begin
          if (cnt_one || cnt_zero) begin
            state_d        = ST_PLAY;
            cnt_load       = 1'b1;
            cnt_load_value = ROUND_T;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      ST_PLAY: begin
        if (phase_tick && !cnt_zero) begin
          cnt_en = 1'b1;
          if (cnt_one) begin
            state_d = ST_OVER;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      score      <= '0;
      mole_en    <= 1'b0;
      round_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      mole_en    <= (state_d == ST_PLAY) && !pause_i;
      round_done <= (state_q == ST_PLAY) && (state_d == ST_OVER);
      if (score_clr) begin
        score <= '0;
      end else if (score_inc) begin
        score <= score + 1'b1;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed and randomized bench for game_round_ctrl against a seconds/score model.
module tb_game_round_ctrl;

  localparam int ROUND_S = 5;
  localparam int READY_S = 3;
  localparam int W       = 18;

  logic       clk_in    = 1'b0;
  logic       rst_n     = 1'b0;
  logic       tick_1hz  = 1'b0;
  logic       start_btn = 1'b0;
  logic       hit       = 1'b0;
  logic       pause_lvl = 1'b0;
  logic [1:0] state;
  logic [5:0] time_left;
  logic [7:0] score;
  logic       mole_en;
  logic       round_done;

  int tests_run = 0;
  int fail_cnt  = 0;

  logic [W-1:0] exp_q[$];

  // Reference model: phase 0 idle, 1 ready, 2 play, 3 over.
  int m_phase, m_time, m_score;
  bit m_mole, m_done;

  // clock / reset
  always #5 clk_in = ~clk_in;

  game_round_ctrl #(
    .ROUND_SECONDS (ROUND_S),
    .READY_SECONDS (READY_S)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .tick_1hz   (tick_1hz),
    .start_btn  (start_btn),
    .hit        (hit),
`ifdef GAME_PAUSE_EN
    .pause      (pause_lvl),
`endif
    .state      (state),
    .time_left  (time_left),
    .score      (score),
    .mole_en    (mole_en),
    .round_done (round_done)
  );

  task automatic model_reset();
    m_phase = 0; m_time = 0; m_score = 0; m_mole = 0; m_done = 0;
  endtask

  task automatic model_step(input bit s, input bit t, input bit h, input bit p);
    int ph;
    ph     = m_phase;
    m_done = 0;
    if (ph == 2 && !p && h && m_score < 255) m_score = m_score + 1;
    if (ph == 0 || ph == 3) begin
      if (s) begin m_phase = 1; m_time = READY_S; m_score = 0; end
    end else if (t && !p) begin
      if (m_time > 1) m_time = m_time - 1;
      else if (ph == 1) begin m_phase = 2; m_time = ROUND_S; end
      else begin m_phase = 3; m_time = 0; m_done = 1; end
    end
    m_mole = (m_phase == 2) && !p;
  endtask

  function automatic logic [W-1:0] model_vec();
    return {m_phase[1:0], m_time[5:0], m_score[7:0], m_mole, m_done};
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // scoreboard: pop the next expected output vector and compare every field
  task automatic check_outputs(input string tag);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    cmp({tag, "/state"},      32'(state),      32'(e[17:16]));
    cmp({tag, "/time_left"},  32'(time_left),  32'(e[15:10]));
    cmp({tag, "/score"},      32'(score),      32'(e[9:2]));
    cmp({tag, "/mole_en"},    32'(mole_en),    32'(e[1]));
    cmp({tag, "/round_done"}, 32'(round_done), 32'(e[0]));
  endtask

  // driver: one clock with the given pulses, then compare outputs
  task automatic step(input string tag, input bit s, input bit t, input bit h);
    start_btn = s; tick_1hz = t; hit = h;
    @(posedge clk_in);
    model_step(s, t, h, pause_lvl);
    exp_q.push_back(model_vec());
    #1;
    start_btn = 1'b0; tick_1hz = 1'b0; hit = 1'b0;
    check_outputs(tag);
  endtask

  task automatic tick_n(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step(tag, 0, 1, 0);
      step(tag, 0, 0, 0);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    exp_q.push_back(model_vec());
    check_outputs("reset");
    rst_n = 1'b1;

    step("idle_hold", 0, 0, 0);
    step("idle_tick_hit", 0, 1, 1);
    step("start_with_tick", 1, 1, 0);
    cmp("start_state", 32'(state), 32'd1);
    cmp("start_time", 32'(time_left), 32'(READY_S));

    step("ready_hit", 0, 0, 1);
    step("ready_hit", 0, 0, 1);
    step("ready_start_ignored", 1, 0, 0);
    tick_n("ready_count", 3);
    cmp("play_state", 32'(state), 32'd2);
    cmp("play_time", 32'(time_left), 32'(ROUND_S));

    for (int i = 0; i < 3; i++) step("play_hit", 0, 0, 1);
    cmp("score_three", 32'(score), 32'd3);
    step("play_start_ignored", 1, 0, 0);
    tick_n("play_count", 4);
    cmp("last_second", 32'(time_left), 32'd1);
    step("final_tick_hit", 0, 1, 1);
    cmp("over_state", 32'(state), 32'd3);
    cmp("over_score", 32'(score), 32'd4);
    cmp("over_done", 32'(round_done), 32'd1);
    step("over_hit_ignored", 0, 1, 1);
    cmp("done_one_cycle", 32'(round_done), 32'd0);

    step("restart", 1, 0, 0);
    cmp("restart_score", 32'(score), 32'd0);
    tick_n("ready2", 3);
    for (int i = 0; i < 300; i++) step("sat_hit", 0, 0, 1);
    cmp("score_saturated", 32'(score), 32'd255);
    tick_n("to_two", 3);
    cmp("time_two", 32'(time_left), 32'd2);

    rst_n = 1'b0;
    #2;
    model_reset();
    exp_q.push_back(model_vec());
    check_outputs("async_reset");
    @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step("post_reset", 0, 1, 0);

`ifdef GAME_PAUSE_EN
    step("p_start", 1, 0, 0);
    tick_n("p_ready", 3);
    tick_n("p_play", 1);
    cmp("p_time_four", 32'(time_left), 32'd4);
    pause_lvl = 1'b1;
    tick_n("paused_tick", 3);
    step("paused_hit", 0, 0, 1);
    step("paused_hit", 0, 0, 1);
    cmp("paused_time", 32'(time_left), 32'd4);
    cmp("paused_score", 32'(score), 32'd0);
    cmp("paused_mole", 32'(mole_en), 32'd0);
    pause_lvl = 1'b0;
    step("resume_tick", 0, 1, 0);
    cmp("resume_time", 32'(time_left), 32'd3);
`endif

    for (int i = 0; i < 600; i++) begin
`ifdef GAME_PAUSE_EN
      if ($urandom_range(0, 9) == 0) pause_lvl = ~pause_lvl;
`endif
      step("random", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
